// File: rtl/setpoint_ctrl.sv
// Up/down setpoint register with programmable step, saturate/wrap range limits,
// hold-to-repeat on two push-button levels, parallel load and enable.
module setpoint_ctrl #(
  parameter int WIDTH    = 16,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 999,
  parameter int RST_VAL  = 0,
  parameter int STEP     = 1,
  parameter int WRAP     = 0,
  parameter int HOLD_CYC = 50_000_000,
  parameter int RPT_CYC  = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_i,
  input  logic             dn_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] val,
  output logic             chg,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RPT  = 2'd2;

  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [31:0]      HOLD_LAST = 32'(HOLD_CYC - 1);
  localparam logic [31:0]      RPT_LAST  = 32'(RPT_CYC - 1);

  // One extra bit keeps val+STEP from overflowing before the range test.
  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] v, input logic up);
    logic [WIDTH:0] s;
    s = {1'b0, v} + STEP_X;
    if (up) begin
      if (s > MAX_X) step_val = (WRAP != 0) ? MIN_V : MAX_V;
      else           step_val = s[WIDTH-1:0];
    end else begin
      if ({1'b0, v} < MIN_X + STEP_X) step_val = (WRAP != 0) ? MAX_V : MIN_V;
      else                            step_val = v - STEP_V;
    end
  endfunction

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    if (int'(v) < MIN_VAL)      clamp = MIN_V;
    else if (int'(v) > MAX_VAL) clamp = MAX_V;
    else                        clamp = v;
  endfunction

  logic [WIDTH-1:0] val_q, val_d;
  logic             chg_q;
  logic [1:0]       st_q, st_d;
  logic [31:0]      tmr_q, tmr_d;
  logic             dir_q, dir_d;
  logic             up_s_q, dn_s_q, up_p_q, dn_p_q;
  logic             press_up, press_dn, held;

  assign press_up = up_s_q & ~up_p_q & ~dn_s_q;
  assign press_dn = dn_s_q & ~dn_p_q & ~up_s_q;
  assign held     = dir_q ? (up_s_q & ~dn_s_q) : (dn_s_q & ~up_s_q);

  always_comb begin
    val_d = val_q;
    st_d  = st_q;
    tmr_d = tmr_q;
    dir_d = dir_q;
    if (load) begin
      val_d = clamp(load_val);
      st_d  = S_IDLE;
      tmr_d = '0;
    end else if (!en) begin
      st_d  = S_IDLE;
      tmr_d = '0;
    end else begin
      case (st_q)
        S_IDLE: begin
          if (press_up || press_dn) begin
            dir_d = press_up;
            val_d = step_val(val_q, press_up);
            tmr_d = '0;
            st_d  = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!held) begin
            st_d  = S_IDLE;
            tmr_d = '0;
          end else if (tmr_q == HOLD_LAST) begin
            val_d = step_val(val_q, dir_q);
            tmr_d = '0;
            st_d  = S_RPT;
          end else begin
            tmr_d = tmr_q + 32'd1;
          end
        end
        S_RPT: begin
          if (!held) begin
            st_d  = S_IDLE;
            tmr_d = '0;
          end else if (tmr_q == RPT_LAST) begin
            val_d = step_val(val_q, dir_q);
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + 32'd1;
          end
        end
        default: begin
          st_d  = S_IDLE;
          tmr_d = '0;
        end
      endcase
    end
  end

  // Level registers reset high so a button held through reset is never a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= RST_V;
      chg_q  <= 1'b0;
      st_q   <= S_IDLE;
      tmr_q  <= '0;
      dir_q  <= 1'b0;
      up_s_q <= 1'b1;
      dn_s_q <= 1'b1;
      up_p_q <= 1'b1;
      dn_p_q <= 1'b1;
    end else begin
      val_q  <= val_d;
      chg_q  <= (val_d != val_q);
      st_q   <= st_d;
      tmr_q  <= tmr_d;
      dir_q  <= dir_d;
      up_s_q <= up_i;
      dn_s_q <= dn_i;
      up_p_q <= up_s_q;
      dn_p_q <= dn_s_q;
    end
  end

  assign val    = val_q;
  assign chg    = chg_q;
  assign at_min = (val_q == MIN_V);
  assign at_max = (val_q == MAX_V);

endmodule

// File: tb/tb_setpoint_ctrl.sv
// Directed bench for setpoint_ctrl: a saturating instance and a wrapping instance
// share stimulus (WIDTH=8, range 10..20, reset 15, step 2, hold 8, repeat 4).
module tb_setpoint_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, up, dn, load;
  logic [7:0] load_val;
  logic [7:0] val0, val1;
  logic       chg0, chg1, min0, min1, max0, max1;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  setpoint_ctrl #(.WIDTH(8), .MIN_VAL(10), .MAX_VAL(20), .RST_VAL(15), .STEP(2),
                  .WRAP(0), .HOLD_CYC(8), .RPT_CYC(4)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_i(up), .dn_i(dn), .load(load),
    .load_val(load_val), .val(val0), .chg(chg0), .at_min(min0), .at_max(max0)
  );

  setpoint_ctrl #(.WIDTH(8), .MIN_VAL(10), .MAX_VAL(20), .RST_VAL(15), .STEP(2),
                  .WRAP(1), .HOLD_CYC(8), .RPT_CYC(4)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up_i(up), .dn_i(dn), .load(load),
    .load_val(load_val), .val(val1), .chg(chg1), .at_min(min1), .at_max(max1)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle button pulse; returns in the cycle the step becomes visible.
  task automatic pulse(input bit is_up);
    if (is_up) up = 1'b1; else dn = 1'b1;
    tick(1);
    up = 1'b0;
    dn = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b0; dn = 1'b0; load = 1'b0; load_val = '0;
    tick(2);
    check("rst_val", val0, 15);
    check("rst_chg", chg0, 0);
    check("rst_at_min", min0, 0);
    check("rst_at_max", max0, 0);
    rst = 1'b0;
    tick(2);

    // single press: one cycle to sample, step on the next edge
    up = 1'b1; tick(1);
    check("t1_latency", val0, 15);
    up = 1'b0; tick(1);
    check("t1_val", val0, 17);
    check("t1_chg", chg0, 1);
    check("t1_at_max", max0, 0);
    tick(1);
    check("t1_chg_pulse", chg0, 0);

    // hold-to-repeat with saturation at the top
    up = 1'b1; tick(2);
    check("t2_step1", val0, 19);
    check("t2_step1_chg", chg0, 1);
    tick(7);
    check("t2_hold_wait", val0, 19);
    check("t2_hold_chg", chg0, 0);
    tick(1);
    check("t2_step2", val0, 20);
    check("t2_step2_chg", chg0, 1);
    check("t2_at_max", max0, 1);
    tick(4);
    check("t2_sat_val", val0, 20);
    check("t2_sat_chg", chg0, 0);
    tick(13);
    check("t2_held_val", val0, 20);
    up = 1'b0; tick(3);

    // parallel load with clamping
    load = 1'b1; load_val = 8'd5; tick(1);
    check("t5_load_lo", val0, 10);
    check("t5_load_lo_chg", chg0, 1);
    check("t5_at_min", min0, 1);
    load_val = 8'd250; tick(1);
    check("t5_load_hi", val0, 20);
    check("t5_load_hi_chg", chg0, 1);
    load_val = 8'd20; tick(1);
    check("t5_load_same_chg", chg0, 0);
    load_val = 8'd14; tick(1);
    load = 1'b0;
    check("t5_load_mid", val0, 14);
    tick(1);

    // both buttons together, then releasing one is not a press of the other
    up = 1'b1; dn = 1'b1; tick(3);
    check("t4_both_val", val0, 14);
    check("t4_both_chg", chg0, 0);
    dn = 1'b0; tick(3);
    check("t4_release_val", val0, 14);
    check("t4_release_chg", chg0, 0);
    up = 1'b0; tick(2);
    pulse(1'b1);
    check("t4_repress_val", val0, 16);
    check("t4_repress_chg", chg0, 1);
    tick(1);

    // load during repeat cancels it until a fresh press
    dn = 1'b1; tick(2);
    check("t5_rpt_step1", val0, 14);
    tick(8);
    check("t5_rpt_step2", val0, 12);
    tick(1);
    load = 1'b1; load_val = 8'd18; tick(1);
    load = 1'b0;
    check("t5_rpt_load", val0, 18);
    check("t5_rpt_load_chg", chg0, 1);
    tick(8);
    check("t5_rpt_stopped", val0, 18);
    dn = 1'b0; tick(2);
    pulse(1'b0);
    check("t5_rpt_repress", val0, 16);
    tick(1);

    // wrapping instance
    load = 1'b1; load_val = 8'd20; tick(1);
    load = 1'b0;
    check("t3_w_load", val1, 20);
    tick(1);
    pulse(1'b0);
    check("t3_w_dn1", val1, 18);
    check("t3_w_dn1_chg", chg1, 1);
    tick(1);
    pulse(1'b0);
    check("t3_w_dn2", val1, 16);
    tick(1);
    load = 1'b1; load_val = 8'd20; tick(1);
    load = 1'b0; tick(1);
    pulse(1'b1);
    check("t3_w_up_wrap", val1, 10);
    check("t3_w_up_wrap_chg", chg1, 1);
    check("t3_w_at_min", min1, 1);
    check("t3_s_up_sat", val0, 20);
    check("t3_s_up_sat_chg", chg0, 0);
    tick(1);
    pulse(1'b0);
    check("t3_w_dn_wrap", val1, 20);
    check("t3_w_at_max", max1, 1);
    tick(1);

    // async reset in the middle of repeat, then enable gating
    load = 1'b1; load_val = 8'd12; tick(1);
    load = 1'b0; tick(1);
    up = 1'b1; tick(2);
    check("t6_step1", val0, 14);
    tick(8);
    check("t6_step2", val0, 16);
    tick(4);
    check("t6_step3", val0, 18);
    tick(1);
    rst = 1'b1; #1;
    check("t6_async_val", val0, 15);
    check("t6_async_chg", chg0, 0);
    tick(2);
    rst = 1'b0; tick(20);
    check("t6_held_val", val0, 15);
    check("t6_held_chg", chg0, 0);
    up = 1'b0; tick(2);
    pulse(1'b1);
    check("t6_repress", val0, 17);
    tick(1);
    en = 1'b0;
    pulse(1'b1);
    check("t6_en0_val", val0, 17);
    check("t6_en0_chg", chg0, 0);
    tick(1);
    up = 1'b1; tick(3);
    en = 1'b1; tick(3);
    check("t6_en_return", val0, 17);
    up = 1'b0; tick(2);
    pulse(1'b1);
    check("t6_en1_step", val0, 19);
    tick(1);
    en = 1'b0;
    load = 1'b1; load_val = 8'd11; tick(1);
    load = 1'b0;
    check("t6_en0_load", val0, 11);
    check("t6_en0_load_chg", chg0, 1);
    en = 1'b1; tick(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
